slave_bus_fabric: RTL and testbench

- N-slave successor to the two-slave bus mux.
- Sits between the core's memory-bus master port and RAM, UART, timer and future peripherals.
- Decodes word addresses against parametrised windows and adds a valid/ready request handshake with multi-cycle slave responses.
- Returns an error response, instead of garbage, on an unmapped access or a slave timeout.

---
 rtl/bus_fabric_pkg.sv | 33 +++
 rtl/bus_addr_decoder.sv | 51 +++++
 rtl/slave_bus_fabric.sv | 250 +++++++++++++++++++++++++
 tb/tb_slave_bus_fabric.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_fabric_pkg.sv
// Shared types and helpers for the slave bus fabric.
//   fabric_state_t : sequencing states of the fabric FSM
//   SIZE_LOG2_W    : width of one log2 window-size field
//   decode_hits    : raw (unprioritised) window hit vector for up to 8 slaves
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } fabric_state_t;

  localparam int SIZE_LOG2_W = 6;
  localparam int DEC_MAX_SLAVES = 8;
  localparam int DEC_ADDR_W = 64;

  // Arguments are zero-extended to fixed maximum widths so one helper serves
  // every parametrisation. Slave k hits when the address and base agree above
  // the window size bits.
  function automatic logic [DEC_MAX_SLAVES-1:0] decode_hits(
    input logic [DEC_ADDR_W-1:0]                  addr,
    input logic [DEC_MAX_SLAVES*DEC_ADDR_W-1:0]   bases,
    input logic [DEC_MAX_SLAVES*SIZE_LOG2_W-1:0]  sizes
  );
    logic [DEC_MAX_SLAVES-1:0] hits;
    for (int k = 0; k < DEC_MAX_SLAVES; k++) begin
      hits[k] = (addr >> sizes[k*SIZE_LOG2_W +: SIZE_LOG2_W]) ==
                (bases[k*DEC_ADDR_W +: DEC_ADDR_W] >> sizes[k*SIZE_LOG2_W +: SIZE_LOG2_W]);
    end
    return hits;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder for the slave bus fabric.
// Ports:
//   addr_i    : master word address
//   hit_o     : one-hot selected slave (lowest index wins on overlap)
//   hit_any_o : address falls in at least one window
//   offset_o  : address minus the selected slave's base (0 when unmapped)
module bus_addr_decoder
  import bus_fabric_pkg::*;
#(
  parameter int                                  N_SLAVES        = 4,
  parameter int                                  ADDR_W          = 30,
  parameter logic [N_SLAVES*ADDR_W-1:0]          SLAVE_BASE      = '0,
  parameter logic [N_SLAVES*SIZE_LOG2_W-1:0]     SLAVE_SIZE_LOG2 = '0
) (
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [N_SLAVES-1:0] hit_o,
  output logic                hit_any_o,
  output logic [ADDR_W-1:0]   offset_o
);

  logic [DEC_ADDR_W-1:0]                 addr_ext;
  logic [DEC_MAX_SLAVES*DEC_ADDR_W-1:0]  bases_ext;
  logic [DEC_MAX_SLAVES*SIZE_LOG2_W-1:0] sizes_ext;
  logic [DEC_MAX_SLAVES-1:0]             raw_hits;
  logic                                  found;

  always_comb begin
    addr_ext  = DEC_ADDR_W'(addr_i);
    bases_ext = '0;
    sizes_ext = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      bases_ext[k*DEC_ADDR_W +: DEC_ADDR_W]   = DEC_ADDR_W'(SLAVE_BASE[k*ADDR_W +: ADDR_W]);
      sizes_ext[k*SIZE_LOG2_W +: SIZE_LOG2_W] = SLAVE_SIZE_LOG2[k*SIZE_LOG2_W +: SIZE_LOG2_W];
    end
    raw_hits = decode_hits(addr_ext, bases_ext, sizes_ext);

    // Priority pick: only slots below N_SLAVES are real windows.
    hit_o    = '0;
    offset_o = '0;
    found    = 1'b0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (raw_hits[k] && !found) begin
        hit_o[k] = 1'b1;
        offset_o = addr_i - SLAVE_BASE[k*ADDR_W +: ADDR_W];
        found    = 1'b1;
      end
    end
    hit_any_o = found;
  end

endmodule

// File: rtl/slave_bus_fabric.sv
// N-slave memory bus fabric: decodes master word addresses onto slave windows,
// issues a one-cycle request strobe, waits for the selected slave's response
// (bounded by TIMEOUT) and returns a one-cycle response to the master. Unmapped
// accesses and timeouts answer with err=1, rdata=0.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   m_req_*/m_addr_i/m_we_i/m_wdata_i/m_mask_byte_i : master request side
//   m_resp_valid_o/m_rdata_o/m_resp_err_o            : master response side
//   s_req_o (one-hot), s_we_o, s_addr_o (window offset), s_wdata_o, s_mask_byte_o
//   s_resp_valid_i, s_rdata_i : per-slave responses, slave 0 in LSBs
// Optional build macro BUS_FABRIC_ERR_CAPTURE_EN adds sticky error capture:
//   err_addr_o, err_kind_o (0=unmapped, 1=timeout), err_clr_i.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | request issued, waiting for selected slave or timeout
// RESP   | result captured; response pulse is driven next cycle
module slave_bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int                              N_SLAVES        = 4,
  parameter int                              ADDR_W          = 30,
  parameter int                              DATA_W          = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0]      SLAVE_BASE      = '0,
  parameter logic [N_SLAVES*SIZE_LOG2_W-1:0] SLAVE_SIZE_LOG2 = '0,
  parameter int                              TIMEOUT         = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_req_valid_i,
  output logic                       m_req_ready_o,
  input  logic [ADDR_W-1:0]          m_addr_i,
  input  logic                       m_we_i,
  input  logic [DATA_W-1:0]          m_wdata_i,
  input  logic [DATA_W/8-1:0]        m_mask_byte_i,
  output logic                       m_resp_valid_o,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic                       m_resp_err_o,
  output logic [N_SLAVES-1:0]        s_req_o,
  output logic                       s_we_o,
  output logic [ADDR_W-1:0]          s_addr_o,
  output logic [DATA_W-1:0]          s_wdata_o,
  output logic [DATA_W/8-1:0]        s_mask_byte_o,
  input  logic [N_SLAVES-1:0]        s_resp_valid_i,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata_i
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0]          err_addr_o,
  output logic                       err_kind_o,
  input  logic                       err_clr_i
`endif
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  fabric_state_t       state_q, state_d;
  logic [N_SLAVES-1:0] sel_q, sel_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [N_SLAVES-1:0] s_req_q, s_req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;
  logic                cap_err_q, cap_err_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [N_SLAVES-1:0] dec_hit;
  logic                dec_hit_any;
  logic [ADDR_W-1:0]   dec_offset;
  logic [DATA_W-1:0]   sel_rdata;
  logic                accept;
  logic                resp_hit;
  logic                timeout_hit;

  bus_addr_decoder #(
    .N_SLAVES        (N_SLAVES),
    .ADDR_W          (ADDR_W),
    .SLAVE_BASE      (SLAVE_BASE),
    .SLAVE_SIZE_LOG2 (SLAVE_SIZE_LOG2)
  ) u_dec (
    .addr_i    (m_addr_i),
    .hit_o     (dec_hit),
    .hit_any_o (dec_hit_any),
    .offset_o  (dec_offset)
  );

  // The response pulse is registered, so ready is also held low during it to
  // keep a new accept from overlapping the previous response.
  assign m_req_ready_o = (state_q == IDLE) && !resp_valid_q;
  assign accept        = m_req_valid_i && m_req_ready_o;
  assign resp_hit      = (state_q == ACCESS) && |(s_resp_valid_i & sel_q);
  assign timeout_hit   = (state_q == ACCESS) && !resp_hit && (cnt_q == TIMEOUT_C);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_q[k]) sel_rdata = sel_rdata | s_rdata_i[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    we_d         = we_q;
    offset_d     = offset_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    s_req_d      = '0;
    cnt_d        = cnt_q;
    cap_data_d   = cap_data_q;
    cap_err_d    = cap_err_q;
    resp_valid_d = 1'b0;
    rdata_d      = '0;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d    = dec_hit;
          we_d     = m_we_i;
          offset_d = dec_offset;
          wdata_d  = m_wdata_i;
          mask_d   = m_mask_byte_i;
          cnt_d    = '0;
          if (dec_hit_any) begin
            s_req_d = dec_hit;
            state_d = ACCESS;
          end else begin
            cap_data_d = '0;
            cap_err_d  = 1'b1;
            state_d    = RESP;
          end
        end
      end
      ACCESS: begin
        // Saturate rather than wrap; the timeout compare leaves ACCESS anyway.
        if (cnt_q != TIMEOUT_C) cnt_d = cnt_q + 1'b1;
        if (resp_hit) begin
          cap_data_d = sel_rdata;
          cap_err_d  = 1'b0;
          state_d    = RESP;
        end else if (timeout_hit) begin
          cap_data_d = '0;
          cap_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        resp_valid_d = 1'b1;
        rdata_d      = cap_data_q;
        err_d        = cap_err_q;
        cnt_d        = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      we_q         <= 1'b0;
      offset_q     <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      s_req_q      <= '0;
      cnt_q        <= '0;
      cap_data_q   <= '0;
      cap_err_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      offset_q     <= offset_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      s_req_q      <= s_req_d;
      cnt_q        <= cnt_d;
      cap_data_q   <= cap_data_d;
      cap_err_q    <= cap_err_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign m_resp_valid_o = resp_valid_q;
  assign m_rdata_o      = rdata_q;
  assign m_resp_err_o   = err_q;
  assign s_req_o        = s_req_q;
  assign s_we_o         = we_q;
  assign s_addr_o       = offset_q;
  assign s_wdata_o      = wdata_q;
  assign s_mask_byte_o  = mask_q;

`ifdef BUS_FABRIC_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              err_kind_q, err_kind_d;
  logic              err_held_q, err_held_d;
  logic              unmapped_evt;

  assign unmapped_evt = (state_q == IDLE) && accept && !dec_hit_any;

  always_comb begin
    addr_d     = accept ? m_addr_i : addr_q;
    err_addr_d = err_addr_q;
    err_kind_d = err_kind_q;
    err_held_d = err_held_q;
    if (err_clr_i) begin
      err_addr_d = '0;
      err_kind_d = 1'b0;
      err_held_d = 1'b0;
    end
    // A clear in the same cycle as a new error still lets the error in.
    if ((unmapped_evt || timeout_hit) && (!err_held_q || err_clr_i)) begin
      err_addr_d = unmapped_evt ? m_addr_i : addr_q;
      err_kind_d = timeout_hit;
      err_held_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      err_addr_q <= '0;
      err_kind_q <= 1'b0;
      err_held_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      err_addr_q <= err_addr_d;
      err_kind_q <= err_kind_d;
      err_held_q <= err_held_d;
    end
  end

  assign err_addr_o = err_addr_q;
  assign err_kind_o = err_kind_q;
`endif

endmodule

// File: tb/tb_slave_bus_fabric.sv
module tb_slave_bus_fabric;

  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_req_valid_i;
  logic          m_req_ready_o;
  logic [29:0]   m_addr_i;
  logic          m_we_i;
  logic [31:0]   m_wdata_i;
  logic [3:0]    m_mask_byte_i;
  logic          m_resp_valid_o;
  logic [31:0]   m_rdata_o;
  logic          m_resp_err_o;
  logic [3:0]    s_req_o;
  logic          s_we_o;
  logic [29:0]   s_addr_o;
  logic [31:0]   s_wdata_o;
  logic [3:0]    s_mask_byte_o;
  logic [3:0]    s_resp_valid_i;
  logic [127:0]  s_rdata_i;
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
  logic [29:0]   err_addr_o;
  logic          err_kind_o;
  logic          err_clr_i;
  bit            m_held;
  logic [29:0]   m_eaddr;
  logic          m_ekind;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory map: word-address base and log2 size per slave.
  // Slaves 2 and 3 overlap on purpose (0x100..0x10F belongs to slave 2).
  longint base [4] = '{64'h000, 64'h040, 64'h100, 64'h100};
  int     sz   [4] = '{6, 2, 4, 8};

  slave_bus_fabric #(
    .N_SLAVES        (4),
    .ADDR_W          (30),
    .DATA_W          (32),
    .SLAVE_BASE      ({30'h100, 30'h100, 30'h040, 30'h000}),
    .SLAVE_SIZE_LOG2 ({6'd8, 6'd4, 6'd2, 6'd6}),
    .TIMEOUT         (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m_req_valid_i  (m_req_valid_i),
    .m_req_ready_o  (m_req_ready_o),
    .m_addr_i       (m_addr_i),
    .m_we_i         (m_we_i),
    .m_wdata_i      (m_wdata_i),
    .m_mask_byte_i  (m_mask_byte_i),
    .m_resp_valid_o (m_resp_valid_o),
    .m_rdata_o      (m_rdata_o),
    .m_resp_err_o   (m_resp_err_o),
    .s_req_o        (s_req_o),
    .s_we_o         (s_we_o),
    .s_addr_o       (s_addr_o),
    .s_wdata_o      (s_wdata_o),
    .s_mask_byte_o  (s_mask_byte_o),
    .s_resp_valid_i (s_resp_valid_i),
    .s_rdata_i      (s_rdata_i)
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    ,
    .err_addr_o     (err_addr_o),
    .err_kind_o     (err_kind_o),
    .err_clr_i      (err_clr_i)
`endif
  );

  always #5 clk = ~clk;

  function automatic int model_sel(input longint a);
    for (int k = 0; k < 4; k++) begin
      if (a / (64'd1 << sz[k]) == base[k] / (64'd1 << sz[k])) return k;
    end
    return -1;
  endfunction

  task automatic model_clear();
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    m_held  = 1'b0;
    m_eaddr = '0;
    m_ekind = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One complete master transaction with a slave answering lat cycles after
  // its request strobe (lat=0: same cycle; lat>TMO or <0: silent).
  task automatic run_txn(input logic [29:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] mask, input int lat, input bit noise, input bit clr_on_err);
    int          sel;
    int          exp_lat;
    int          seen;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] sdata [4];
    logic [3:0]  onehot;
    logic [3:0]  rv;
    logic [29:0] exp_off;
    bit          answers;

    sel     = model_sel(longint'(addr));
    answers = (sel >= 0) && (lat >= 0) && (lat <= TMO);
    onehot  = (sel >= 0) ? (4'b0001 << sel) : 4'b0000;
    exp_off = (sel >= 0) ? 30'(longint'(addr) - base[sel]) : 30'd0;
    for (int k = 0; k < 4; k++) sdata[k] = $urandom;
    s_rdata_i = {sdata[3], sdata[2], sdata[1], sdata[0]};
    if (sel < 0) begin
      exp_lat = 2; exp_err = 1'b1; exp_rdata = '0;
    end else if (answers) begin
      exp_lat = lat + 3; exp_err = 1'b0; exp_rdata = sdata[sel];
    end else begin
      exp_lat = TMO + 3; exp_err = 1'b1; exp_rdata = '0;
    end

    @(negedge clk);
    n_checks++;
    if (m_req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL ready_idle: got %b expected 1", m_req_ready_o);
    end
    m_req_valid_i = 1'b1; m_addr_i = addr; m_we_i = we; m_wdata_i = wdata; m_mask_byte_i = mask;
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    err_clr_i = clr_on_err && (sel < 0);
`endif

    seen = -1;
    for (int c = 1; c <= TMO + 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Scramble master inputs: slave-side broadcast must not follow them.
        m_req_valid_i = 1'b0; m_addr_i = 30'($urandom); m_we_i = ~we;
        m_wdata_i = ~wdata; m_mask_byte_i = ~mask;
        n_checks++;
        if (m_rdata_o !== 32'd0 || m_resp_err_o !== 1'b0) begin
          n_fail++; $display("FAIL resp_idle_zero: got rdata=%h err=%b expected 0/0", m_rdata_o, m_resp_err_o);
        end
      end
      n_checks++;
      if (s_req_o !== ((c == 1) ? onehot : 4'b0000)) begin
        n_fail++; $display("FAIL s_req addr=%h cyc=%0d: got %b expected %b", addr, c, s_req_o, (c == 1) ? onehot : 4'b0000);
      end
      if (sel >= 0 && c <= exp_lat - 2) begin
        n_checks++;
        if ({s_we_o, s_addr_o, s_wdata_o, s_mask_byte_o} !== {we, exp_off, wdata, mask}) begin
          n_fail++;
          $display("FAIL broadcast cyc=%0d: got we=%b addr=%h wdata=%h mask=%b expected we=%b addr=%h wdata=%h mask=%b",
                   c, s_we_o, s_addr_o, s_wdata_o, s_mask_byte_o, we, exp_off, wdata, mask);
        end
      end
      if (m_resp_valid_o === 1'b1) begin
        seen = c;
        n_checks++;
        if (m_rdata_o !== exp_rdata || m_resp_err_o !== exp_err || m_req_ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL response addr=%h: got rdata=%h err=%b ready=%b expected rdata=%h err=%b ready=0",
                   addr, m_rdata_o, m_resp_err_o, m_req_ready_o, exp_rdata, exp_err);
        end
        break;
      end
      rv = 4'b0000;
      if (sel >= 0 && c - 1 == lat) rv = onehot;
      if (noise) rv = rv | (4'($urandom) & ~onehot);
      s_resp_valid_i = rv;
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
      err_clr_i = clr_on_err && (sel >= 0) && !answers && (c == TMO + 1);
`endif
    end
    s_resp_valid_i = 4'b0000;
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    err_clr_i = 1'b0;
`endif
    n_checks++;
    if (seen != exp_lat) begin
      n_fail++; $display("FAIL latency addr=%h: got %0d expected %0d", addr, seen, exp_lat);
    end

    @(negedge clk);
    n_checks++;
    if (m_resp_valid_o !== 1'b0 || m_req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL pulse_end: got valid=%b ready=%b expected 0/1", m_resp_valid_o, m_req_ready_o);
    end

`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    if (clr_on_err && exp_err) begin
      m_held = 1'b0; m_eaddr = '0; m_ekind = 1'b0;
    end
    if (exp_err && !m_held) begin
      m_held = 1'b1; m_eaddr = addr; m_ekind = (sel >= 0);
    end
    n_checks++;
    if (err_addr_o !== m_eaddr || err_kind_o !== m_ekind) begin
      n_fail++; $display("FAIL err_capture: got addr=%h kind=%b expected addr=%h kind=%b", err_addr_o, err_kind_o, m_eaddr, m_ekind);
    end
`endif
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (m_req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", m_req_ready_o);
    end
    n_checks++;
    if ({m_resp_valid_o, m_rdata_o, m_resp_err_o} !== 34'd0) begin
      n_fail++; $display("FAIL reset_resp: got valid=%b rdata=%h err=%b expected 0", m_resp_valid_o, m_rdata_o, m_resp_err_o);
    end
    n_checks++;
    if ({s_req_o, s_we_o, s_addr_o, s_wdata_o, s_mask_byte_o} !== 71'd0) begin
      n_fail++; $display("FAIL reset_slave_side: got req=%b we=%b addr=%h wdata=%h mask=%b expected 0", s_req_o, s_we_o, s_addr_o, s_wdata_o, s_mask_byte_o);
    end
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    n_checks++;
    if (err_addr_o !== 30'd0 || err_kind_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_err_capture: got addr=%h kind=%b expected 0", err_addr_o, err_kind_o);
    end
`endif
  endtask

  task automatic test_read_same_cycle();
    run_txn(30'h0003, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_write();
    run_txn(30'h0041, 1'b1, 32'h0000_00A5, 4'b0001, 2, 1'b0, 1'b0);
  endtask

  task automatic test_unmapped();
    run_txn(30'h2000, 1'b0, 32'h0, 4'hF, 0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(30'h0041, 1'b0, 32'h0, 4'hF, -1, 1'b1, 1'b0);
    // Response in the very cycle the counter hits TIMEOUT still counts as good.
    run_txn(30'h0010, 1'b0, 32'h0, 4'hF, TMO, 1'b1, 1'b0);
  endtask

  task automatic test_overlap();
    run_txn(30'h0105, 1'b0, 32'h0, 4'hF, 1, 1'b0, 1'b0);
    run_txn(30'h0150, 1'b1, 32'h1234_5678, 4'b1010, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid(input int rst_c);
    bit got;
    @(negedge clk);
    m_req_valid_i = 1'b1; m_addr_i = 30'h0003; m_we_i = 1'b0;
    @(negedge clk);
    m_req_valid_i = 1'b0;
    for (int c = 1; c < rst_c; c++) @(negedge clk);
    // Slave answers in the reset cycle; that response must be dropped.
    s_resp_valid_i = 4'b0001;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_resp_valid_i = 4'b0000;
    model_clear();
    n_checks++;
    if (s_req_o !== 4'b0000 || m_req_ready_o !== 1'b1 || m_resp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid c=%0d: got req=%b ready=%b valid=%b expected 0000/1/0", rst_c, s_req_o, m_req_ready_o, m_resp_valid_o);
    end
    got = 1'b0;
    repeat (TMO + 4) begin
      @(negedge clk);
      if (m_resp_valid_o === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (got !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_no_resp c=%0d: got pulse=%b expected 0", rst_c, got);
    end
    run_txn(30'h0003, 1'b0, 32'h0, 4'hF, 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [29:0] a;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: a = 30'($urandom_range(0, 63));
        1: a = 30'(32'h40 + $urandom_range(0, 3));
        2: a = 30'(32'h100 + $urandom_range(0, 15));
        3: a = 30'(32'h110 + $urandom_range(0, 239));
        4: a = 30'($urandom_range(32'h200, 32'hFFFF));
        default: a = 30'($urandom_range(32'h44, 32'hFF));
      endcase
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 11)) - 1,
              1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
  endtask

`ifdef BUS_FABRIC_ERR_CAPTURE_EN
  task automatic test_err_capture();
    apply_reset();
    run_txn(30'h2000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0);
    run_txn(30'h0041, 1'b0, 32'h0, 4'hF, -1, 1'b0, 1'b0);
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    model_clear();
    n_checks++;
    if (err_addr_o !== 30'd0 || err_kind_o !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got addr=%h kind=%b expected 0", err_addr_o, err_kind_o);
    end
    run_txn(30'h0041, 1'b0, 32'h0, 4'hF, -1, 1'b0, 1'b0);
    run_txn(30'h3000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    rst = 1'b1; m_req_valid_i = 1'b0; m_addr_i = '0; m_we_i = 1'b0;
    m_wdata_i = '0; m_mask_byte_i = '0; s_resp_valid_i = '0; s_rdata_i = '0;
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    err_clr_i = 1'b0;
`endif
    model_clear();
    test_reset();
    test_read_same_cycle();
    test_write();
    test_unmapped();
    test_timeout();
    test_overlap();
    test_reset_mid(1);
    test_reset_mid(3);
    test_random();
`ifdef BUS_FABRIC_ERR_CAPTURE_EN
    test_err_capture();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
